// File: rtl/uart_cfg.sv
// Parameterised UART: AXI-stream style TX/RX with configurable data width, parity and stop bits.
// Bit period is prescale*8 clk cycles; each channel latches prescale at frame start.
module uart_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     input_axis_tdata,
  input  logic                      input_axis_tvalid,
  output logic                      input_axis_tready,
  output logic [DATA_WIDTH-1:0]     output_axis_tdata,
  output logic                      output_axis_tvalid,
  input  logic                      output_axis_tready,
  input  logic                      rxd,
  output logic                      txd,
  output logic                      tx_busy,
  output logic                      rx_busy,
  output logic                      rx_overrun_error,
  output logic                      rx_frame_error,
  output logic                      rx_parity_error,
  input  logic [PRESCALE_WIDTH-1:0] prescale
);

  localparam int CW = PRESCALE_WIDTH + 3;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [PRESCALE_WIDTH-1:0] presc_eff;
  assign presc_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;

  function automatic logic [CW-1:0] full_cnt(input logic [PRESCALE_WIDTH-1:0] p);
    return {p, 3'b000} - CW'(1);
  endfunction

  function automatic logic [CW-1:0] half_cnt(input logic [PRESCALE_WIDTH-1:0] p);
    return {1'b0, p, 2'b00} - CW'(1);
  endfunction

  function automatic logic par_bit(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // ---------------- transmitter ----------------
  state_t                    tx_state, tx_state_n;
  logic [CW-1:0]             tx_cnt, tx_cnt_n;
  logic [3:0]                tx_bit, tx_bit_n;
  logic [DATA_WIDTH-1:0]     tx_shift, tx_shift_n;
  logic                      tx_par, tx_par_n;
  logic [PRESCALE_WIDTH-1:0] tx_presc, tx_presc_n;
  logic                      txd_q, txd_n;
  logic                      tx_rdy, tx_rdy_n;
  logic                      tx_busy_q, tx_busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_presc  <= '0;
      txd_q     <= 1'b1;
      tx_rdy    <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_shift  <= tx_shift_n;
      tx_par    <= tx_par_n;
      tx_presc  <= tx_presc_n;
      txd_q     <= txd_n;
      tx_rdy    <= tx_rdy_n;
      tx_busy_q <= tx_busy_n;
    end
  end

  // Outputs are computed one cycle ahead so txd/tready/busy come straight from flops.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_presc_n = tx_presc;
    txd_n      = txd_q;
    tx_rdy_n   = tx_rdy;
    tx_busy_n  = tx_busy_q;
    unique case (tx_state)
      ST_IDLE: begin
        tx_rdy_n  = 1'b1;
        tx_busy_n = 1'b0;
        txd_n     = 1'b1;
        if (input_axis_tvalid && tx_rdy) begin
          tx_state_n = ST_START;
          tx_presc_n = presc_eff;
          tx_cnt_n   = full_cnt(presc_eff);
          tx_shift_n = input_axis_tdata;
          tx_par_n   = par_bit(input_axis_tdata);
          txd_n      = 1'b0;
          tx_rdy_n   = 1'b0;
          tx_busy_n  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CW'(1);
        end else begin
          tx_state_n = ST_DATA;
          tx_cnt_n   = full_cnt(tx_presc);
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
          tx_shift_n = tx_shift >> 1;
        end
      end
      ST_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CW'(1);
        end else begin
          tx_cnt_n = full_cnt(tx_presc);
          if (tx_bit == 4'(DATA_WIDTH - 1)) begin
            tx_bit_n = '0;
            if (PARITY != 0) begin
              tx_state_n = ST_PARITY;
              txd_n      = tx_par;
            end else begin
              tx_state_n = ST_STOP;
              txd_n      = 1'b1;
            end
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            txd_n      = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CW'(1);
        end else begin
          tx_state_n = ST_STOP;
          tx_cnt_n   = full_cnt(tx_presc);
          tx_bit_n   = '0;
          txd_n      = 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CW'(1);
        end else if (tx_bit == 4'(STOP_BITS - 1)) begin
          tx_state_n = ST_IDLE;
          tx_rdy_n   = 1'b1;
          tx_busy_n  = 1'b0;
          txd_n      = 1'b1;
        end else begin
          tx_bit_n = tx_bit + 4'd1;
          tx_cnt_n = full_cnt(tx_presc);
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  assign txd               = txd_q;
  assign input_axis_tready = tx_rdy;
  assign tx_busy           = tx_busy_q;

  // ---------------- receiver ----------------
  logic                      sync1, sync2, rxs_d;
  state_t                    rx_state, rx_state_n;
  logic [CW-1:0]             rx_cnt, rx_cnt_n;
  logic [3:0]                rx_bit, rx_bit_n;
  logic [DATA_WIDTH-1:0]     rx_shift, rx_shift_n;
  logic                      rx_par, rx_par_n;
  logic [PRESCALE_WIDTH-1:0] rx_presc, rx_presc_n;
  logic                      rx_busy_q, rx_busy_n;
  logic [DATA_WIDTH-1:0]     out_data, out_data_n;
  logic                      out_valid, out_valid_n;
  logic                      ovr_q, ovr_n, fe_q, fe_n, pe_q, pe_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rxs_d     <= 1'b1;
      rx_state  <= ST_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      rx_presc  <= '0;
      rx_busy_q <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      rxs_d     <= sync2;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_par    <= rx_par_n;
      rx_presc  <= rx_presc_n;
      rx_busy_q <= rx_busy_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      ovr_q     <= ovr_n;
      fe_q      <= fe_n;
      pe_q      <= pe_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_par_n    = rx_par;
    rx_presc_n  = rx_presc;
    rx_busy_n   = rx_busy_q;
    out_data_n  = out_data;
    out_valid_n = out_valid && !output_axis_tready;
    ovr_n       = 1'b0;
    fe_n        = 1'b0;
    pe_n        = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        if (rxs_d && !sync2) begin
          rx_state_n = ST_START;
          rx_presc_n = presc_eff;
          rx_cnt_n   = half_cnt(presc_eff);
          rx_busy_n  = 1'b1;
        end
      end
      ST_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CW'(1);
        end else if (sync2) begin
          rx_state_n = ST_IDLE;
          rx_busy_n  = 1'b0;
        end else begin
          rx_state_n = ST_DATA;
          rx_cnt_n   = full_cnt(rx_presc);
          rx_bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CW'(1);
        end else begin
          rx_cnt_n   = full_cnt(rx_presc);
          rx_shift_n = {sync2, rx_shift[DATA_WIDTH-1:1]};
          if (rx_bit == 4'(DATA_WIDTH - 1)) begin
            rx_bit_n = '0;
            if (PARITY != 0) rx_state_n = ST_PARITY;
            else             rx_state_n = ST_STOP;
          end else begin
            rx_bit_n = rx_bit + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CW'(1);
        end else begin
          rx_par_n   = sync2;
          rx_state_n = ST_STOP;
          rx_cnt_n   = full_cnt(rx_presc);
        end
      end
      ST_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CW'(1);
        end else begin
          // Only the first stop bit is checked; extra stop bits are idle time.
          rx_state_n = ST_IDLE;
          rx_busy_n  = 1'b0;
          if (!sync2) begin
            fe_n = 1'b1;
          end else if (PARITY != 0 && rx_par != par_bit(rx_shift)) begin
            pe_n = 1'b1;
          end else begin
            out_data_n  = rx_shift;
            out_valid_n = 1'b1;
            ovr_n       = out_valid && !output_axis_tready;
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  assign output_axis_tdata  = out_data;
  assign output_axis_tvalid = out_valid;
  assign rx_busy            = rx_busy_q;
  assign rx_overrun_error   = ovr_q;
  assign rx_frame_error     = fe_q;
  assign rx_parity_error    = pe_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: four instances (default, 7E1, 8O1 injected, 8N2) with prescale=2.
// Frames are checked bit-by-bit on txd and end-to-end through RX.
module tb_uart_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3;
  logic [15:0] prescale;
  logic [7:0]  td0, td2, td3;
  logic [6:0]  td1;
  logic        tv0, tv1, tv2, tv3;
  logic        tr0, tr1, tr2, tr3;
  logic [7:0]  od0, od2, od3;
  logic [6:0]  od1;
  logic        ov0, ov1, ov2, ov3;
  logic        ordy0, ordy1, ordy2, ordy3;
  logic        txd0, txd1, txd2, txd3;
  logic        rxd2;
  logic        txb0, txb1, txb2, txb3;
  logic        rxb0, rxb1, rxb2, rxb3;
  logic        ovr0, ovr1, ovr2, ovr3;
  logic        fe0, fe1, fe2, fe3;
  logic        pe0, pe1, pe2, pe3;

  uart_cfg #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .PRESCALE_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .input_axis_tdata(td0), .input_axis_tvalid(tv0), .input_axis_tready(tr0),
    .output_axis_tdata(od0), .output_axis_tvalid(ov0), .output_axis_tready(ordy0),
    .rxd(txd0), .txd(txd0), .tx_busy(txb0), .rx_busy(rxb0), .rx_overrun_error(ovr0),
    .rx_frame_error(fe0), .rx_parity_error(pe0), .prescale(prescale));

  uart_cfg #(.DATA_WIDTH(7), .PARITY(2), .STOP_BITS(1), .PRESCALE_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .input_axis_tdata(td1), .input_axis_tvalid(tv1), .input_axis_tready(tr1),
    .output_axis_tdata(od1), .output_axis_tvalid(ov1), .output_axis_tready(ordy1),
    .rxd(txd1), .txd(txd1), .tx_busy(txb1), .rx_busy(rxb1), .rx_overrun_error(ovr1),
    .rx_frame_error(fe1), .rx_parity_error(pe1), .prescale(prescale));

  uart_cfg #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .PRESCALE_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .input_axis_tdata(td2), .input_axis_tvalid(tv2), .input_axis_tready(tr2),
    .output_axis_tdata(od2), .output_axis_tvalid(ov2), .output_axis_tready(ordy2),
    .rxd(rxd2), .txd(txd2), .tx_busy(txb2), .rx_busy(rxb2), .rx_overrun_error(ovr2),
    .rx_frame_error(fe2), .rx_parity_error(pe2), .prescale(prescale));

  uart_cfg #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2), .PRESCALE_WIDTH(16)) u3 (
    .clk(clk), .rst(rst3), .input_axis_tdata(td3), .input_axis_tvalid(tv3), .input_axis_tready(tr3),
    .output_axis_tdata(od3), .output_axis_tvalid(ov3), .output_axis_tready(ordy3),
    .rxd(txd3), .txd(txd3), .tx_busy(txb3), .rx_busy(rxb3), .rx_overrun_error(ovr3),
    .rx_frame_error(fe3), .rx_parity_error(pe3), .prescale(prescale));

  logic [3:0] ovv, ordyv, fev, pev, ovrv;
  logic [8:0] od_a [4];
  assign ovv   = {ov3, ov2, ov1, ov0};
  assign ordyv = {ordy3, ordy2, ordy1, ordy0};
  assign fev   = {fe3, fe2, fe1, fe0};
  assign pev   = {pe3, pe2, pe1, pe0};
  assign ovrv  = {ovr3, ovr2, ovr1, ovr0};
  assign od_a[0] = {1'b0, od0};
  assign od_a[1] = {2'b00, od1};
  assign od_a[2] = {1'b0, od2};
  assign od_a[3] = {1'b0, od3};

  // Handshake and error-pulse counters (pulse counters count high cycles).
  int         vcnt [4];
  int         fecnt [4];
  int         pecnt [4];
  int         ovcnt [4];
  logic [8:0] last [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ovv[i] && ordyv[i]) begin
        vcnt[i] <= vcnt[i] + 1;
        last[i] <= od_a[i];
      end
      if (fev[i])  fecnt[i] <= fecnt[i] + 1;
      if (pev[i])  pecnt[i] <= pecnt[i] + 1;
      if (ovrv[i]) ovcnt[i] <= ovcnt[i] + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic txd_of(input int i);
    case (i)
      0: return txd0;
      1: return txd1;
      2: return txd2;
      default: return txd3;
    endcase
  endfunction

  function automatic logic tready_of(input int i);
    case (i)
      0: return tr0;
      1: return tr1;
      2: return tr2;
      default: return tr3;
    endcase
  endfunction

  function automatic logic tbusy_of(input int i);
    case (i)
      0: return txb0;
      1: return txb1;
      2: return txb2;
      default: return txb3;
    endcase
  endfunction

  function automatic int errs(input int i);
    return fecnt[i] + pecnt[i] + ovcnt[i];
  endfunction

  task automatic set_tx(input int i, input logic [7:0] d, input logic v);
    case (i)
      0: begin td0 = d; tv0 = v; end
      1: begin td1 = d[6:0]; tv1 = v; end
      2: begin td2 = d; tv2 = v; end
      default: begin td3 = d; tv3 = v; end
    endcase
  endtask

  // Returns 1 time unit after the transfer edge.
  task automatic send(input int i, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    set_tx(i, d, 1'b1);
    while (!tready_of(i) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_wait", 32'(n < 1000), 1);
    @(posedge clk);
    #1 set_tx(i, d, 1'b0);
  endtask

  task automatic frame_check(input int i, input logic [15:0] bits, input int nbits,
                             output int bad, output int rdy_hi, output int busy_lo,
                             output logic [15:0] mid);
    bad = 0; rdy_hi = 0; busy_lo = 0; mid = '0;
    for (int k = 0; k < nbits * 16; k++) begin
      @(negedge clk);
      if (txd_of(i) !== bits[k / 16]) bad++;
      if (k % 16 == 8) mid[k / 16] = txd_of(i);
      if (tready_of(i)) rdy_hi++;
      if (!tbusy_of(i)) busy_lo++;
    end
  endtask

  task automatic inject(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      rxd2 = f[b];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    rxd2 = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, rh, bl, bv, be, bp, bf, seen;
    logic [15:0] mid;
    rst = 1'b1; rst3 = 1'b1; prescale = 16'd2; rxd2 = 1'b1;
    td0 = '0; td1 = '0; td2 = '0; td3 = '0;
    tv0 = 1'b0; tv1 = 1'b0; tv2 = 1'b0; tv3 = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1; ordy3 = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_txd", {txd3, txd2, txd1, txd0}, 32'hF);
    check("rst_tready", {tr3, tr2, tr1, tr0}, 0);
    check("rst_tvalid", ovv, 0);
    check("rst_tdata", {od0, od2, od3, od1}, 0);
    check("rst_busy", {txb3, txb2, txb1, txb0, rxb3, rxb2, rxb1, rxb0}, 0);
    check("rst_err", {fev, pev, ovrv}, 0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {tr3, tr2, tr1, tr0}, 32'hF);

    // 8N1 loopback, 0x55
    bv = vcnt[0]; be = errs(0);
    send(0, 8'h55);
    frame_check(0, 16'h02AA, 10, bad, rh, bl, mid);
    check("s1_frame_bits", bad, 0);
    check("s1_tready_low", rh, 0);
    check("s1_busy_high", bl, 0);
    @(negedge clk);
    check("s1_tready_back", tr0, 1);
    check("s1_busy_clear", txb0, 0);
    n = 0;
    while (vcnt[0] == bv && n < 200) begin @(negedge clk); n++; end
    check("s1_rx_wait", 32'(n < 200), 1);
    check("s1_rx_data", last[0], 9'h055);
    check("s1_rx_errs", errs(0) - be, 0);

    // 7E1 loopback, 0x2A -> parity bit 1
    bv = vcnt[1]; be = errs(1);
    send(1, 8'h2A);
    frame_check(1, 16'h0354, 10, bad, rh, bl, mid);
    check("s2_frame_bits", bad, 0);
    check("s2_parity_bit", mid[8], 1);
    n = 0;
    while (vcnt[1] == bv && n < 200) begin @(negedge clk); n++; end
    check("s2_rx_wait", 32'(n < 200), 1);
    check("s2_rx_data", last[1], 9'h02A);
    check("s2_rx_errs", errs(1) - be, 0);

    // 8O1 injected: wrong parity, then good frame, then bad stop, then glitch
    bv = vcnt[2]; bp = pecnt[2]; bf = fecnt[2];
    inject(8'h0F, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("s3_perr_pulse", pecnt[2] - bp, 1);
    check("s3_perr_nodata", vcnt[2] - bv, 0);
    check("s3_perr_tvalid", ov2, 0);
    check("s3_perr_noframe", fecnt[2] - bf, 0);
    inject(8'h0F, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("s3_good_count", vcnt[2] - bv, 1);
    check("s3_good_data", last[2], 9'h00F);
    check("s3_good_perr", pecnt[2] - bp, 1);
    bv = vcnt[2]; bp = pecnt[2]; bf = fecnt[2];
    inject(8'h3C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("s4_ferr_pulse", fecnt[2] - bf, 1);
    check("s4_ferr_nodata", vcnt[2] - bv, 0);
    check("s4_ferr_noperr", pecnt[2] - bp, 0);
    repeat (20) @(negedge clk);
    @(negedge clk); rxd2 = 1'b0;
    @(negedge clk); rxd2 = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (rxb2) seen = 1; end
    check("s4_glitch_busy", seen, 1);
    repeat (60) @(negedge clk);
    check("s4_glitch_idle", rxb2, 0);
    check("s4_glitch_nodata", vcnt[2] - bv, 0);
    check("s4_glitch_noerr", errs(2) - (bf + bp + 1), 0);

    // 8N1 back-to-back with consumer stalled -> overrun
    ordy0 = 1'b0;
    bv = vcnt[0]; be = ovcnt[0];
    @(negedge clk);
    set_tx(0, 8'hAA, 1'b1);
    n = 0;
    while (!tr0 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 td0 = 8'h3C;
    n = 0;
    do begin @(negedge clk); n++; end while (!tr0 && n < 1000);
    check("s5_second_ready", n, 161);
    @(posedge clk);
    #1 tv0 = 1'b0;
    @(negedge clk);
    check("s5_second_start", txd0, 0);
    n = 0;
    while (ovcnt[0] == be && n < 400) begin @(negedge clk); n++; end
    check("s5_ovr_wait", 32'(n < 400), 1);
    repeat (3) @(negedge clk);
    check("s5_ovr_once", ovcnt[0] - be, 1);
    check("s5_tvalid_held", ov0, 1);
    check("s5_tdata_new", od0, 8'h3C);
    ordy0 = 1'b1;
    @(negedge clk);
    check("s5_consumed", ov0, 0);
    check("s5_handshakes", vcnt[0] - bv, 1);
    check("s5_consumed_data", last[0], 9'h03C);

    // 8N2: reset halfway through a frame, then a clean frame
    bv = vcnt[3]; be = errs(3);
    send(3, 8'h33);
    repeat (88) @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    check("s6_rst_txd", txd3, 1);
    check("s6_rst_tready", tr3, 0);
    check("s6_rst_busy", {txb3, rxb3}, 0);
    check("s6_rst_tvalid", ov3, 0);
    rst3 = 1'b0;
    @(negedge clk);
    check("s6_ready_after_rst", tr3, 1);
    repeat (250) @(negedge clk);
    check("s6_abort_nodata", vcnt[3] - bv, 0);
    check("s6_abort_noerr", errs(3) - be, 0);
    send(3, 8'hA5);
    frame_check(3, 16'h074A, 11, bad, rh, bl, mid);
    check("s6_frame_bits", bad, 0);
    n = 0;
    while (vcnt[3] == bv && n < 200) begin @(negedge clk); n++; end
    check("s6_rx_wait", 32'(n < 200), 1);
    check("s6_rx_data", last[3], 9'h0A5);
    check("s6_rx_errs", errs(3) - be, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-004 The block SHALL have parameter PRESCALE_WIDTH, default 16, width of the prescale port.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous active-high reset).
REQ-006 The block SHALL have the following data and status ports:
- input_axis_tdata, input, DATA_WIDTH: TX data.
- input_axis_tvalid, input, 1: TX data valid.
- input_axis_tready, output, 1: TX ready.
- output_axis_tdata, output, DATA_WIDTH: RX data.
- output_axis_tvalid, output, 1: RX data valid.
- output_axis_tready, input, 1: RX consumer ready.
- rxd, input, 1: asynchronous serial in.
- txd, output, 1: serial out.
- tx_busy, output, 1: TX frame in progress.
- rx_busy, output, 1: RX frame in progress.
- rx_overrun_error, output, 1: one-cycle pulse.
- rx_frame_error, output, 1: one-cycle pulse.
- rx_parity_error, output, 1: one-cycle pulse.
- prescale, input, PRESCALE_WIDTH: clk / (baud*8).

Function
REQ-007 The bit period SHALL be prescale*8 clk cycles; a prescale of 0 SHALL be treated as 1.
REQ-008 Each channel SHALL latch prescale at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-009 Frame format SHALL be: start (0), DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits (1); idle line is 1.
REQ-010 The parity bit SHALL make the count of 1s over data+parity odd (PARITY=1) or even (PARITY=2).
REQ-011 TX handshake: input_axis_tready=1 only in TX IDLE; transfer on tvalid&tready.
- tready SHALL be 0 and tx_busy SHALL be 1 from the cycle after the transfer until the last stop bit completes.
REQ-012 txd SHALL drive the start bit from the cycle after the transfer; each bit is held exactly one bit period.
REQ-013 TX FSM states SHALL be IDLE -> START -> DATA (DATA_WIDTH bits) -> PARITY (skipped if PARITY=0) -> STOP (STOP_BITS periods) -> IDLE.
- tready SHALL reassert the cycle after STOP ends, giving back-to-back frames with no idle gap.
REQ-014 rxd SHALL pass through a 2-flop synchronizer before use; all RX timing is relative to the synchronized signal.
REQ-015 RX FSM states SHALL be IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- A falling edge in IDLE SHALL enter START and set rx_busy.
REQ-016 RX sampling: start is sampled prescale*4 cycles after the edge; if the sample is 1 (glitch), RX SHALL return to IDLE with no output and no error.
- Each following bit SHALL be sampled prescale*8 cycles after the previous sample.
REQ-017 With STOP_BITS=2, RX SHALL check only the first stop bit and SHALL return to IDLE after sampling it.
REQ-018 At the stop sample, the frame SHALL be resolved with this priority:
- stop=0: rx_frame_error pulses, data discarded.
- else parity mismatch: rx_parity_error pulses, data discarded.
- else output_axis_tdata is loaded and output_axis_tvalid set the next cycle.
REQ-019 output_axis_tvalid SHALL clear on tvalid&tready.
- A new good frame arriving while tvalid=1 and not consumed in that cycle SHALL overwrite tdata, keep tvalid=1 and pulse rx_overrun_error.
REQ-020 Simultaneous consume and new-frame load SHALL load the new data, keep tvalid=1 and raise no overrun.
REQ-021 rx_busy SHALL clear in the cycle after the stop sample, and RX SHALL accept a new falling edge from then on.
REQ-022 TX and RX SHALL be fully independent; loopback of txd to rxd SHALL be supported.

Reset
REQ-023 While rst=1, both FSMs SHALL be forced to IDLE and counters cleared.
- txd=1, input_axis_tready=0, output_axis_tvalid=0, output_axis_tdata=0, tx_busy=0, rx_busy=0, all error outputs 0, synchronizer flops=1.
REQ-024 input_axis_tready SHALL go to 1 the first cycle after rst deasserts.
REQ-025 Reset mid-frame SHALL abort both channels immediately; a partial RX frame SHALL produce no output and no error.

Verification
REQ-026 The bench SHALL cover these directed scenarios, all in loopback unless stated:
- Defaults, prescale=2, send 0x55: txd low 16 cycles per bit, 10-bit frame = 160 cycles, rx tdata=0x55, no errors.
- PARITY=2, DATA_WIDTH=7, send 0x2A: parity bit=1 on txd, rx tdata=0x2A, rx_parity_error=0.
- Non-loopback, PARITY=1, inject a frame with wrong parity: rx_parity_error one-cycle pulse, output_axis_tvalid stays 0.
- Inject a frame with stop=0: rx_frame_error pulse, no data output; then a 1-cycle low glitch on rxd in IDLE: no output, no error.
- output_axis_tready=0, send 0xAA then 0x3C back-to-back: second frame starts right after the first stop; rx_overrun_error pulses once, tdata=0x3C.
- STOP_BITS=2, assert rst halfway through a frame: txd=1 next cycle, no rx output; following frame 0xA5 received correctly.
